// File: rtl/matrix_key_scan.sv
// matrix_key_scan: 4x4 keypad scanner with debounced press/release detection.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   row[3:0]   in   pulled-up row lines, 0 = key pressed in the driven column
//   col[3:0]   out  active-low column drive, exactly one bit low
//   key_code   out  accepted key index = row_idx*4 + col_idx
//   key_valid  out  one-cycle pulse when key_code is (re)issued
//   key_held   out  high while an accepted key is considered pressed
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat pulses
// (REPEAT_DELAY frames after acceptance, then every REPEAT_RATE frames).
`timescale 1ns/1ps
module matrix_key_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_e;

  logic [3:0]       row_meta_q, row_meta_d, row_sync_q, row_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      acc_q, acc_d, frame_q, frame_d;
  logic             frame_rdy_q, frame_rdy_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             res_none_s, res_single_s, accept_s, rep_pulse_s;
  logic [3:0]       code_s;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_TOP = REP_W'(REPEAT_DELAY + REPEAT_RATE);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != REPEAT_RATE);
`endif

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // Frame classification: one-hot test and encoded position of the single key
  assign res_none_s   = (frame_q == 16'd0);
  assign res_single_s = !res_none_s && ((frame_q & (frame_q - 16'd1)) == 16'd0);
  assign code_s = {|(frame_q & 16'hFF00), |(frame_q & 16'hF0F0),
                   |(frame_q & 16'hCCCC), |(frame_q & 16'hAAAA)};

  // Synchronizer, column divider and frame accumulation
  always_comb begin
    row_meta_d  = row;
    row_sync_d  = row_meta_q;
    div_d       = div_q;
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    acc_d       = acc_q;
    frame_d     = frame_q;
    frame_rdy_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d     = {DIV_W{1'b0}};
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(4'b0001 << col_idx_d);
      // Accumulator bit r*4+c is set when row r reads low for column c
      case (col_idx_q)
        2'd0:    {acc_d[12], acc_d[8], acc_d[4], acc_d[0]} = ~row_sync_q;
        2'd1:    {acc_d[13], acc_d[9], acc_d[5], acc_d[1]} = ~row_sync_q;
        2'd2:    {acc_d[14], acc_d[10], acc_d[6], acc_d[2]} = ~row_sync_q;
        2'd3:    {acc_d[15], acc_d[11], acc_d[7], acc_d[3]} = ~row_sync_q;
        default: acc_d = acc_q;
      endcase
      if (col_idx_q == 2'd3) begin
        frame_d     = acc_d;
        acc_d       = 16'd0;
        frame_rdy_d = 1'b1;
      end else begin
        frame_rdy_d = 1'b0;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Next-state logic, evaluated once per completed frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (frame_rdy_q) begin
      case (state_q)
        S_IDLE: begin
          if (res_single_s) begin
            cand_d = code_s;
            if (DB_MAX == CNT_W'(1)) begin
              state_d = S_PRESSED;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = {CNT_W{1'b0}};
          end
        end
        S_DEBOUNCE: begin
          if (res_single_s && (code_s == cand_q)) begin
            if ((cnt_q + CNT_W'(1)) == DB_MAX) begin
              state_d = S_PRESSED;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end
        end
        S_PRESSED: begin
          // Any key activity keeps the press; a new key needs a release first
          if (res_none_s) begin
            if (DB_MAX == CNT_W'(1)) begin
              state_d = S_IDLE;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              state_d = S_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            state_d = S_PRESSED;
          end
        end
        S_RELEASE: begin
          if (res_none_s) begin
            if ((cnt_q + CNT_W'(1)) == DB_MAX) begin
              state_d = S_IDLE;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_PRESSED;
            cnt_d   = {CNT_W{1'b0}};
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic: acceptance pulse, optional repeat pulses, held flag
  always_comb begin
    accept_s = frame_rdy_q && (state_d == S_PRESSED) &&
               ((state_q == S_IDLE) || (state_q == S_DEBOUNCE));
    rep_pulse_s = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d = rep_q;
    if ((state_q == S_PRESSED) && (state_d == S_PRESSED)) begin
      if (frame_rdy_q && res_single_s && (code_s == cand_q)) begin
        if ((rep_q + REP_W'(1)) == REP_TOP) begin
          rep_d       = REP_DLY;
          rep_pulse_s = 1'b1;
        end else begin
          rep_d       = rep_q + REP_W'(1);
          rep_pulse_s = ((rep_q + REP_W'(1)) == REP_DLY);
        end
      end else begin
        rep_d = rep_q;
      end
    end else begin
      rep_d = {REP_W{1'b0}};
    end
`endif
    key_valid_d = accept_s || rep_pulse_s;
    if (accept_s) begin
      key_code_d = cand_d;
    end else begin
      key_code_d = key_code_q;
    end
    key_held_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      div_q       <= {DIV_W{1'b0}};
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      acc_q       <= 16'd0;
      frame_q     <= 16'd0;
      frame_rdy_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q       <= {REP_W{1'b0}};
`endif
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      frame_q     <= frame_d;
      frame_rdy_q <= frame_rdy_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Testbench for matrix_key_scan (SCAN_DIV=4, DEBOUNCE_CNT=3, 16-cycle frames).
// A keypad emulator pulls rows low from the pressed-key mask and the column
// drive; a frame-level model predicts col/key_valid/key_code/key_held.
`timescale 1ns/1ps
module tb_matrix_key_scan;
  localparam int DB = 3;
  localparam int RD = 8;
  localparam int RR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys;
  logic [15:0] kbit;
  logic [3:0]  cbit;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int base;

  // model state
  int          cyc;
  logic [15:0] fk;
  bit          m_held;
  int          m_cnt;
  int          m_cand;
  int          m_rep;
  logic [3:0]  e_code, e_col;
  bit          e_valid, e_held, mdl_on;

  matrix_key_scan #(
    .SCAN_DIV(4), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // keypad emulation: row r reads low if key r*4+c is down and column c driven
  always_comb begin
    row  = 4'b1111;
    kbit = 16'd0;
    cbit = 4'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        kbit = keys >> (r * 4 + c);
        cbit = col >> c;
        if (kbit[0] && !cbit[0]) row = row & ~(4'b0001 << r);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level behavioural model
  task automatic eval_frame();
    int n, c;
    n = $countones(fk);
    c = (n == 1) ? $clog2(fk) : -1;
    if (!m_held) begin
      if (n == 1) begin
        if (m_cnt == 0) begin m_cand = c; m_cnt = 1; end
        else if (c == m_cand) m_cnt++;
        else m_cnt = 0;
        if (m_cnt == DB) begin
          m_held = 1; m_cnt = 0; m_rep = 0; e_valid = 1; e_code = 4'(m_cand);
        end
      end else m_cnt = 0;
    end else begin
      if (n == 0) begin
        m_cnt++; m_rep = 0;
        if (m_cnt == DB) begin m_held = 0; m_cnt = 0; end
      end else begin
        if (m_cnt == 0 && n == 1 && c == m_cand) begin
`ifdef KEY_REPEAT_EN
          m_rep++;
          if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RR == 0)) e_valid = 1;
`endif
        end
        m_cnt = 0;
      end
    end
    e_held = m_held;
  endtask

  initial begin
    cyc = 0; fk = 16'd0; m_held = 0; m_cnt = 0; m_cand = 0; m_rep = 0;
    e_code = 4'd0; e_col = 4'b1110; e_valid = 0; e_held = 0; mdl_on = 0;
    forever begin
      @(posedge clk);
      e_valid = 0;
      if (rst) begin
        cyc = 0; fk = 16'd0; m_held = 0; m_cnt = 0; m_rep = 0;
        e_code = 4'd0; e_held = 0;
      end else begin
        cyc++;
        if (cyc % 16 == 8) fk = keys;
        if (cyc % 16 == 1 && cyc > 1) eval_frame();
      end
      e_col = ~(4'b0001 << ((cyc / 4) % 4));
      mdl_on = 1;
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (mdl_on) begin
      check("col", 16'(col), 16'(e_col));
      check("key_valid", 16'(key_valid), 16'(e_valid));
      check("key_held", 16'(key_held), 16'(e_held));
      check("key_code", 16'(key_code), 16'(e_code));
      if (key_valid) pulses++;
    end
  end

  task automatic frames(input int n);
    repeat (n * 16) @(posedge clk);
    #1;
  endtask

  task automatic frames_plus1(input int n);
    repeat (n * 16 + 1) @(posedge clk);
    #1;
  endtask

  task automatic realign();
    repeat (15) @(posedge clk);
    #1;
  endtask

  initial begin
    keys = 16'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_col", 16'(col), 16'h000E);
    check("rst_code", 16'(key_code), 16'h0000);
    check("rst_valid", 16'(key_valid), 16'h0000);
    check("rst_held", 16'(key_held), 16'h0000);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("col_step0", 16'(col), 16'h000E);
    @(posedge clk); #1;
    check("col_step1", 16'(col), 16'h000D);
    repeat (4) @(posedge clk); #1;
    check("col_step2", 16'(col), 16'h000B);
    repeat (4) @(posedge clk); #1;
    check("col_step3", 16'(col), 16'h0007);
    repeat (4) @(posedge clk); #1;
    check("col_wrap", 16'(col), 16'h000E);

    // clean press of key 9 (row2/col1), then release
    base = pulses;
    keys = 16'h0200;
    frames(3);
    check("k9_not_early", 16'(key_valid), 16'h0000);
    @(posedge clk); #1;
    check("k9_valid", 16'(key_valid), 16'h0001);
    check("k9_code", 16'(key_code), 16'h0009);
    check("k9_held", 16'(key_held), 16'h0001);
    realign();
    frames(2);
    keys = 16'h0000;
    frames(3);
    check("k9_held_release", 16'(key_held), 16'h0001);
    @(posedge clk); #1;
    check("k9_released", 16'(key_held), 16'h0000);
    realign();
    check("k9_pulses", 16'(pulses - base), 16'h0001);

    // bouncing key 3
    base = pulses;
    keys = 16'h0008; frames(2);
    keys = 16'h0000; frames(1);
    keys = 16'h0008; frames(2);
    keys = 16'h0000; frames(4);
    check("bounce_pulses", 16'(pulses - base), 16'h0000);
    check("bounce_held", 16'(key_held), 16'h0000);

    // two keys together, then key 6 alone
    base = pulses;
    keys = 16'h0041; frames(10);
    check("multi_pulses", 16'(pulses - base), 16'h0000);
    keys = 16'h0040;
    frames_plus1(3);
    check("k6_valid", 16'(key_valid), 16'h0001);
    check("k6_code", 16'(key_code), 16'h0006);
    realign();
    keys = 16'h0000; frames(4);

    // key 5 accepted, reset mid frame 6 while held
    keys = 16'h0020;
    frames_plus1(3);
    check("k5_valid", 16'(key_valid), 16'h0001);
    check("k5_code", 16'(key_code), 16'h0005);
    realign();
    frames(1);
    repeat (8) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_col", 16'(col), 16'h000E);
    check("midrst_code", 16'(key_code), 16'h0000);
    check("midrst_held", 16'(key_held), 16'h0000);
    rst = 1'b0;
    base = pulses;
    repeat (48) @(posedge clk); #1;
    check("k5_re_not_early", 16'(key_valid), 16'h0000);
    @(posedge clk); #1;
    check("k5_re_valid", 16'(key_valid), 16'h0001);
    check("k5_re_code", 16'(key_code), 16'h0005);
    realign();
    check("k5_re_pulses", 16'(pulses - base), 16'h0001);
    keys = 16'h0000; frames(4);

    // key 15 held 20 frames: repeat pulses only with the feature enabled
    base = pulses;
    keys = 16'h8000; frames(20);
    keys = 16'h0000; frames(4);
`ifdef KEY_REPEAT_EN
    check("k15_pulses", 16'(pulses - base), 16'h0004);
`else
    check("k15_pulses", 16'(pulses - base), 16'h0001);
`endif
    check("k15_code", 16'(key_code), 16'h000F);
    check("k15_held", 16'(key_held), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
